// File: rtl/adder_nbit_serial_pkg.sv
// ---------------------------------------------------------------------------
// adder_nbit_serial_pkg
//   Shared definitions for the digit-serial adder/subtractor:
//     - FSM state encodings (2-bit, legacy-compatible constants)
//     - clog2 helper used to size the digit counter
//   No ports; imported by adder_nbit_serial and digit_adder.
// ---------------------------------------------------------------------------
package adder_nbit_serial_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ceiling log2; clog2(1) == 0, so callers must clamp to at least 1 bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_nbit_serial_digit_adder.sv
// ---------------------------------------------------------------------------
// digit_adder
//   Combinational W-bit ripple-carry slice used once per cycle by the
//   digit-serial adder.
//   Ports:
//     a, b      in  W  operand slices
//     cin       in  1  carry into bit 0
//     s         out W  slice sum
//     cout      out 1  carry out of bit W-1
//     c_msb_in  out 1  carry into bit W-1 (needed for signed overflow)
// ---------------------------------------------------------------------------
module digit_adder
    import adder_nbit_serial_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    // A scalar running carry avoids a self-referencing carry vector.
    always_comb begin
        logic carry;
        carry    = cin;
        s        = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                c_msb_in = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/adder_nbit_serial.sv
// ---------------------------------------------------------------------------
// adder_nbit_serial
//   Multi-cycle N-bit adder/subtractor processing DIGIT bits per cycle,
//   least-significant digit first, through a single digit_adder slice.
//   Ports:
//     clk    in  1  clock, rising edge
//     rst    in  1  synchronous active-high reset
//     start  in  1  request, accepted when ready=1
//     sub    in  1  0: A+B, 1: A-B (sampled on accept)
//     A, B   in  N  operands (sampled on accept)
//     ready  out 1  new request can be accepted
//     valid  out 1  one-cycle pulse, S/Co/Ovf final
//     S      out N  result modulo 2^N
//     Co     out 1  carry out of bit N-1 (sub: 1 = no borrow)
//     Ovf    out 1  signed overflow
// ---------------------------------------------------------------------------
module adder_nbit_serial
    import adder_nbit_serial_pkg::*;
#(
    parameter int N     = 32,
    parameter int DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         ready,
    output logic         valid,
    output logic [N-1:0] S,
    output logic         Co,
    output logic         Ovf
);

    localparam int NDIG = N / DIGIT;
    localparam int CW   = (NDIG > 1) ? clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

    if (N < 2 || DIGIT < 1 || DIGIT > N || (N % DIGIT) != 0) begin : g_bad_params
        $error("adder_nbit_serial: N must be >= 2 and a multiple of DIGIT");
    end

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     s_q, s_d;
    logic             c_q, c_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] slice_s;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             accept;
    logic             last;

    // Operand registers shift right each RUN cycle, so the active slice is
    // always their low DIGIT bits.
    digit_adder #(.W(DIGIT)) u_slice (
        .a        (a_q[DIGIT-1:0]),
        .b        (b_q[DIGIT-1:0]),
        .cin      (c_q),
        .s        (slice_s),
        .cout     (slice_cout),
        .c_msb_in (slice_cmsb)
    );

    assign ready  = (state_q != ST_RUN);
    assign valid  = (state_q == ST_DONE);
    assign accept = start & ready;
    assign last   = (cnt_q == LAST_DIGIT);

    assign S   = s_q;
    assign Co  = co_q;
    assign Ovf = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_RUN: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (cnt_q == CW'(i)) begin
                        s_d[i*DIGIT +: DIGIT] = slice_s;
                    end
                end
                c_d   = slice_cout;
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    // The last slice holds bit N-1, so its carries give Co/Ovf.
                    co_d    = slice_cout;
                    ovf_d   = slice_cout ^ slice_cmsb;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
        if (accept) begin
            a_d     = A;
            b_d     = B ^ {N{sub}};
            c_d     = sub;
            s_d     = '0;
            cnt_d   = '0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_adder_nbit_serial.sv
// ---------------------------------------------------------------------------
// tb_adder_nbit_serial
//   Directed bench for adder_nbit_serial (N=8, DIGIT=2) plus exhaustive
//   N=4 instances with DIGIT=1, 2 and 4.
// ---------------------------------------------------------------------------
module tb_adder_nbit_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] A;
    logic [7:0] B;
    logic       ready;
    logic       valid;
    logic [7:0] S;
    logic       Co;
    logic       Ovf;

    logic       e_start;
    logic       e_sub;
    logic [3:0] e_A;
    logic [3:0] e_B;
    logic       e_ready [3];
    logic       e_valid [3];
    logic [3:0] e_S     [3];
    logic       e_Co    [3];
    logic       e_Ovf   [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adder_nbit_serial #(.N(8), .DIGIT(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
        .ready(ready), .valid(valid), .S(S), .Co(Co), .Ovf(Ovf)
    );

    adder_nbit_serial #(.N(4), .DIGIT(1)) u_e1 (
        .clk(clk), .rst(rst), .start(e_start), .sub(e_sub), .A(e_A), .B(e_B),
        .ready(e_ready[0]), .valid(e_valid[0]), .S(e_S[0]), .Co(e_Co[0]), .Ovf(e_Ovf[0])
    );

    adder_nbit_serial #(.N(4), .DIGIT(2)) u_e2 (
        .clk(clk), .rst(rst), .start(e_start), .sub(e_sub), .A(e_A), .B(e_B),
        .ready(e_ready[1]), .valid(e_valid[1]), .S(e_S[1]), .Co(e_Co[1]), .Ovf(e_Ovf[1])
    );

    adder_nbit_serial #(.N(4), .DIGIT(4)) u_e4 (
        .clk(clk), .rst(rst), .start(e_start), .sub(e_sub), .A(e_A), .B(e_B),
        .ready(e_ready[2]), .valid(e_valid[2]), .S(e_S[2]), .Co(e_Co[2]), .Ovf(e_Ovf[2])
    );

    // Issue one request on the 8-bit DUT and wait (bounded) for valid.
    // lat counts rising edges after the accept edge; 20 means timeout.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          output logic [7:0] so, output logic co, output logic ov,
                          output int lat);
        @(negedge clk);
        A = a; B = b; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        so = S; co = Co; ov = Ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        e_start = 1'b0; e_sub = 1'b0; e_A = '0; e_B = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests++;
        if ({ready, valid, S, Co, Ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state ready/valid/S/Co/Ovf actual=%b/%b/%h/%b/%b required=1/0/00/0/0",
                     ready, valid, S, Co, Ovf);
        end
    endtask

    task automatic test_add();
        logic [7:0] so; logic co, ov; int lat;
        run_op(8'hFF, 8'h01, 1'b0, so, co, ov, lat);
        tests++;
        if (lat != 4) begin
            fails++; $display("FAIL add_ff_01_latency actual=%0d required=4", lat);
        end
        tests++;
        if ({so, co, ov} !== {8'h00, 1'b1, 1'b0}) begin
            fails++; $display("FAIL add_ff_01 S/Co/Ovf actual=%h/%b/%b required=00/1/0", so, co, ov);
        end
        run_op(8'h7F, 8'h01, 1'b0, so, co, ov, lat);
        tests++;
        if (lat != 4 || {so, co, ov} !== {8'h80, 1'b0, 1'b1}) begin
            fails++; $display("FAIL add_7f_01 lat/S/Co/Ovf actual=%0d/%h/%b/%b required=4/80/0/1", lat, so, co, ov);
        end
    endtask

    task automatic test_sub();
        logic [7:0] so; logic co, ov; int lat;
        run_op(8'h05, 8'h07, 1'b1, so, co, ov, lat);
        tests++;
        if (lat != 4 || {so, co, ov} !== {8'hFE, 1'b0, 1'b0}) begin
            fails++; $display("FAIL sub_05_07 lat/S/Co/Ovf actual=%0d/%h/%b/%b required=4/fe/0/0", lat, so, co, ov);
        end
        run_op(8'h80, 8'h01, 1'b1, so, co, ov, lat);
        tests++;
        if (lat != 4 || {so, co, ov} !== {8'h7F, 1'b1, 1'b1}) begin
            fails++; $display("FAIL sub_80_01 lat/S/Co/Ovf actual=%0d/%h/%b/%b required=4/7f/1/1", lat, so, co, ov);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic rdy_bad; logic ready_at_valid;
        @(negedge clk);
        A = 8'h10; B = 8'h20; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        // start stays high through RUN with new operands on the bus
        A = 8'hAA; B = 8'h55;
        lat = 0; rdy_bad = 1'b0;
        while (valid !== 1'b1 && lat < 20) begin
            if (ready !== 1'b0) rdy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        ready_at_valid = ready;
        tests++;
        if (rdy_bad !== 1'b0) begin
            fails++; $display("FAIL b2b_ready_low_in_run actual=%b required=0", rdy_bad);
        end
        tests++;
        if (lat != 4 || S !== 8'h30 || ready_at_valid !== 1'b1) begin
            fails++; $display("FAIL b2b_first lat/S/ready actual=%0d/%h/%b required=4/30/1", lat, S, ready_at_valid);
        end
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat != 4 || {S, Co, Ovf} !== {8'hFF, 1'b0, 1'b0}) begin
            fails++; $display("FAIL b2b_second lat/S/Co/Ovf actual=%0d/%h/%b/%b required=4/ff/0/0", lat, S, Co, Ovf);
        end
    endtask

    task automatic test_reset_in_run();
        logic [7:0] so; logic co, ov; int lat; logic seen; logic rdy_run;
        @(negedge clk);
        A = 8'h33; B = 8'h44; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rdy_run = ready;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (rdy_run !== 1'b0) begin
            fails++; $display("FAIL rst_run_precheck ready actual=%b required=0", rdy_run);
        end
        tests++;
        if ({ready, valid, S} !== {1'b1, 1'b0, 8'h00}) begin
            fails++; $display("FAIL rst_run_state ready/valid/S actual=%b/%b/%h required=1/0/00", ready, valid, S);
        end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (valid === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++; $display("FAIL rst_run_no_valid actual=%b required=0", seen);
        end
        run_op(8'h03, 8'h04, 1'b0, so, co, ov, lat);
        tests++;
        if (lat != 4 || {so, co, ov} !== {8'h07, 1'b0, 1'b0}) begin
            fails++; $display("FAIL rst_run_after lat/S/Co/Ovf actual=%0d/%h/%b/%b required=4/07/0/0", lat, so, co, ov);
        end
    endtask

    task automatic test_exhaustive();
        int         got_lat [3];
        logic [5:0] got_r   [3];
        int         exp_lat [3];
        logic [3:0] a4, b4, bb;
        logic [4:0] sum5;
        logic       s1, exp_ov;
        exp_lat[0] = 4; exp_lat[1] = 2; exp_lat[2] = 1;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int si = 0; si < 2; si++) begin
                    a4 = 4'(ai); b4 = 4'(bi); s1 = (si != 0);
                    bb = s1 ? ~b4 : b4;
                    sum5 = {1'b0, a4} + {1'b0, bb} + {4'b0, s1};
                    exp_ov = (a4[3] == bb[3]) && (sum5[3] != a4[3]);
                    @(negedge clk);
                    e_A = a4; e_B = b4; e_sub = s1; e_start = 1'b1;
                    @(posedge clk); #1;
                    e_start = 1'b0;
                    for (int d = 0; d < 3; d++) begin
                        got_lat[d] = 0; got_r[d] = '0;
                    end
                    for (int c = 1; c <= 4; c++) begin
                        @(posedge clk); #1;
                        for (int d = 0; d < 3; d++) begin
                            if (got_lat[d] == 0 && e_valid[d] === 1'b1) begin
                                got_lat[d] = c;
                                got_r[d] = {e_Co[d], e_S[d], e_Ovf[d]};
                            end
                        end
                    end
                    for (int d = 0; d < 3; d++) begin
                        tests++;
                        if (got_lat[d] != exp_lat[d] || e_ready[d] !== 1'b1 ||
                            got_r[d] !== {sum5[4], sum5[3:0], exp_ov}) begin
                            fails++;
                            $display("FAIL exh_d%0d a=%h b=%h sub=%b lat/CoSOvf actual=%0d/%b required=%0d/%b",
                                     d, a4, b4, s1, got_lat[d], got_r[d], exp_lat[d],
                                     {sum5[4], sum5[3:0], exp_ov});
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_in_run();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
